// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO from the CPU store path to the UART transmitter.
// Define UART_TX_FIFO_STATS_EN to build the sticky overflow flag and dropped-write counter.
module uart_tx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             cpu_ready,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             ovf_sticky,
  output logic [15:0]      ovf_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;

  // Flags come only from the registered count, so wr_en/tx_ready never reach them.
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign cpu_ready = ~full;
  assign tx_valid  = ~empty;
  assign tx_data   = mem[rd_ptr_reg];

  // A pop in the same cycle does not make room for a write against a full FIFO.
  assign push = wr_en & ~full;
  assign pop  = tx_valid & tx_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage is left unreset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

`ifdef UART_TX_FIFO_STATS_EN
  logic        ovf_sticky_reg;
  logic [15:0] ovf_count_reg;
  logic        drop;

  assign drop = wr_en & full;

  // Survives flush so software can still see drops that preceded it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_reg <= 1'b0;
      ovf_count_reg  <= '0;
    end else if (drop) begin
      ovf_sticky_reg <= 1'b1;
      if (ovf_count_reg != 16'hFFFF) ovf_count_reg <= ovf_count_reg + 16'd1;
    end
  end

  assign ovf_sticky = ovf_sticky_reg;
  assign ovf_count  = ovf_count_reg;
`else
  assign ovf_sticky = 1'b0;
  assign ovf_count  = 16'h0000;
`endif

endmodule
